// File: rtl/key_matrix_scan_pkg.sv
// key_matrix_scan_pkg: shared matrix geometry, debounce state encoding and key-code helper
package key_matrix_scan_pkg;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 5;
  localparam logic [4:0] KEY_NONE = 5'd0;
  typedef enum logic [1:0] {S_REL, S_PWAIT, S_PRS, S_RWAIT} deb_state_t;
  function automatic logic [4:0] key_code(input logic [1:0] col, input logic [2:0] row);
    return 5'(col) * 5'd5 + 5'(row) + 5'd1;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: frame-level press/release debouncer for the decoded key code
// ports: i_clk, i_rstn (async, active-low), i_frame_done/i_frame_code (one pulse per scan frame),
//        o_key_code/o_key_valid (held key), o_key_press/o_key_release (1-cycle pulses)
module key_debounce
  import key_matrix_scan_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_frame_done,
  input  logic [4:0] i_frame_code,
  output logic [4:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_press,
  output logic       o_key_release
);
  localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);
  deb_state_t r_state, w_state;
  logic [3:0] r_cnt, w_cnt, w_inc;
  logic [4:0] r_cand, w_cand, r_code, w_code;
  logic r_valid, w_valid, r_press, w_press, r_rel, w_rel, w_accept, w_drop;
  assign w_inc = (r_cnt == DF) ? DF : r_cnt + 4'd1;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_REL;
      r_cnt   <= '0;
      r_cand  <= KEY_NONE;
      r_code  <= KEY_NONE;
      r_valid <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_cand  <= w_cand;
      r_code  <= w_code;
      r_valid <= w_valid;
      r_press <= w_press;
      r_rel   <= w_rel;
    end
  end
  // accept/drop are resolved after the case so DEBOUNCE_FRAMES==1 can skip the wait states
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_cand   = r_cand;
    w_code   = r_code;
    w_valid  = r_valid;
    w_press  = 1'b0;
    w_rel    = 1'b0;
    w_accept = 1'b0;
    w_drop   = 1'b0;
    if (i_frame_done) begin
      case (r_state)
        S_REL: if (i_frame_code != KEY_NONE) begin
          w_state  = S_PWAIT;
          w_cand   = i_frame_code;
          w_cnt    = 4'd1;
          w_accept = DF == 4'd1;
        end
        S_PWAIT: begin
          if (i_frame_code == KEY_NONE) begin
            w_state = S_REL;
          end else if (i_frame_code == r_cand) begin
            w_cnt    = w_inc;
            w_accept = w_inc == DF;
          end else begin
            w_cand = i_frame_code;
            w_cnt  = 4'd1;
          end
        end
        S_PRS: if (i_frame_code != r_code) begin
          w_state = S_RWAIT;
          w_cnt   = 4'd1;
          w_drop  = DF == 4'd1;
        end
        default: begin
          if (i_frame_code == r_code) begin
            w_state = S_PRS;
          end else begin
            w_cnt  = w_inc;
            w_drop = w_inc == DF;
          end
        end
      endcase
    end
    if (w_accept) begin
      w_state = S_PRS;
      w_code  = w_cand;
      w_valid = 1'b1;
      w_press = 1'b1;
    end
    if (w_drop) begin
      w_state = S_REL;
      w_code  = KEY_NONE;
      w_valid = 1'b0;
      w_rel   = 1'b1;
    end
  end
  assign o_key_code    = r_code;
  assign o_key_valid   = r_valid;
  assign o_key_press   = r_press;
  assign o_key_release = r_rel;
endmodule

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: 4x5 key matrix scanner with single-key decode and frame debouncing
// ports: i_clk, i_rstn (async, active-low), i_key_in (row lines, async), o_key_out (one-hot column strobe),
//        o_key_code (1..20, 0 = none), o_key_valid, o_key_press, o_key_release
module key_matrix_scan
  import key_matrix_scan_pkg::*;
#(
  parameter int COL_TICKS       = 2500,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [NUM_ROWS-1:0] i_key_in,
  output logic [NUM_COLS-1:0] o_key_out,
  output logic [4:0]          o_key_code,
  output logic                o_key_valid,
  output logic                o_key_press,
  output logic                o_key_release
);
  localparam int TW = $clog2(COL_TICKS);
  logic [NUM_ROWS-1:0] r_sync1, r_sync2;
  logic [TW-1:0] r_tick;
  logic [1:0] r_col, r_hits, w_hits;
  logic [NUM_COLS-1:0] r_strobe;
  logic [4:0] r_code, r_frame_code, w_code;
  logic r_frame_done, w_slot_end, w_last_col;
  logic [2:0] w_nrow, w_row, w_sum;
  assign w_slot_end = r_tick == TW'(COL_TICKS - 1);
  assign w_last_col = r_col == 2'd3;
  assign w_nrow     = 3'($countones(r_sync2));
  always_comb begin
    w_row = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) w_row = r_sync2[i] ? 3'(i) : w_row;
  end
  // hits saturate at 2: anything beyond one hit per frame is rejected as "none"
  assign w_sum  = {1'b0, r_hits} + w_nrow;
  assign w_hits = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_code = (w_nrow == 3'd1) ? key_code(r_col, w_row) : r_code;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_tick       <= '0;
      r_col        <= '0;
      r_strobe     <= 4'b0001;
      r_hits       <= '0;
      r_code       <= KEY_NONE;
      r_frame_done <= 1'b0;
      r_frame_code <= KEY_NONE;
    end else begin
      r_sync1      <= i_key_in;
      r_sync2      <= r_sync1;
      r_tick       <= w_slot_end ? '0 : r_tick + 1'b1;
      r_frame_done <= w_slot_end && w_last_col;
      if (w_slot_end) begin
        r_col    <= r_col + 2'd1;
        r_strobe <= {r_strobe[NUM_COLS-2:0], r_strobe[NUM_COLS-1]};
        r_hits   <= w_last_col ? 2'd0 : w_hits;
        r_code   <= w_last_col ? KEY_NONE : w_code;
        if (w_last_col) r_frame_code <= (w_hits == 2'd1) ? w_code : KEY_NONE;
      end
    end
  end
  assign o_key_out = r_strobe;
  key_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_debounce (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_frame_done (r_frame_done),
    .i_frame_code (r_frame_code),
    .o_key_code   (o_key_code),
    .o_key_valid  (o_key_valid),
    .o_key_press  (o_key_press),
    .o_key_release(o_key_release)
  );
endmodule

// File: tb/tb_key_matrix_scan.sv
// tb_key_matrix_scan: randomized frame-level check of the key matrix scanner against a run-length debounce model
module tb_key_matrix_scan;
  localparam int CT = 8;
  localparam int DF = 3;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [4:0] key_in;
  logic [3:0] key_out;
  logic [4:0] key_code;
  logic key_valid, key_press, key_release;
  logic [19:0] pressed = '0;
  int n_tests = 0, n_fail = 0;
  int n_press = 0, n_rel = 0, n_both = 0;
  int m_valid = 0, m_code = 0, m_run = 0, m_prev = 0, m_press = 0, m_rel = 0;
  int prev_fc = 0;
  bit have_prev = 0;
  key_matrix_scan #(.COL_TICKS(CT), .DEBOUNCE_FRAMES(DF)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_key_in     (key_in),
    .o_key_out    (key_out),
    .o_key_code   (key_code),
    .o_key_valid  (key_valid),
    .o_key_press  (key_press),
    .o_key_release(key_release)
  );
  always #5 clk = ~clk;
  always_comb begin
    key_in = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 5; r++)
        if (key_out[c] && pressed[c*5+r]) key_in[r] = 1'b1;
  end
  always @(negedge clk) begin
    if (key_press) n_press++;
    if (key_release) n_rel++;
    if (key_press && key_release) n_both++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int frame_of(input logic [19:0] p);
    int k = 0;
    if ($countones(p) != 1) return 0;
    for (int i = 0; i < 20; i++) if (p[i]) k = i + 1;
    return k;
  endfunction
  function automatic logic [19:0] key(input int k);
    logic [19:0] one = 20'd1;
    return (k == 0) ? 20'd0 : one << (k - 1);
  endfunction
  task automatic model_step(input int fc);
    if (m_valid == 0) begin
      m_run  = (fc != 0 && fc == m_prev) ? m_run + 1 : (fc != 0 ? 1 : 0);
      m_prev = fc;
      if (m_run == DF) begin
        m_valid = 1; m_code = fc; m_press++; m_run = 0;
      end
    end else begin
      m_run = (fc == m_code) ? 0 : m_run + 1;
      if (m_run == DF) begin
        m_valid = 0; m_code = 0; m_rel++; m_run = 0; m_prev = 0;
      end
    end
  endtask
  task automatic run_frame(input logic [19:0] keys);
    logic [31:0] one = 32'd1;
    if (have_prev) model_step(prev_fc);
    pressed = keys;
    repeat (4) @(negedge clk);
    check("strobe_col0", key_out, 4'b0001);
    check("key_code", key_code, m_code);
    check("key_valid", key_valid, m_valid);
    check("press_count", n_press, m_press);
    check("release_count", n_rel, m_rel);
    for (int c = 1; c < 4; c++) begin
      repeat (8) @(negedge clk);
      check("strobe_col", key_out, one << c);
    end
    repeat (4) @(negedge clk);
    prev_fc = frame_of(keys);
    have_prev = 1;
  endtask
  task automatic hold(input logic [19:0] keys, input int frames);
    for (int i = 0; i < frames; i++) run_frame(keys);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_strobe", key_out, 4'b0001);
    check("rst_code", key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_press", key_press, 0);
    check("rst_release", key_release, 0);
    rstn = 1'b1;
    hold(key(0), 10);
    hold(key(7), 10);
    check("held_7", key_code, 7);
    hold(key(0), 6);
    for (int i = 0; i < 4; i++) begin
      run_frame(key(13));
      run_frame(key(0));
    end
    check("bounce_no_press", n_press, 1);
    hold(key(13), 6);
    check("held_13", key_code, 13);
    hold(key(0), 5);
    hold(key(1) | key(20), 6);
    check("ghost_none", key_valid, 0);
    hold(key(20), 5);
    hold(key(5), 8);
    check("held_5", key_code, 5);
    hold(key(0), 5);
    hold(key(20), 5);
    check("pre_rst_valid", key_valid, 1);
    check("pre_rst_code", key_code, 20);
    #3 rstn = 1'b0;
    #1;
    check("async_rst_strobe", key_out, 4'b0001);
    check("async_rst_code", key_code, 0);
    check("async_rst_valid", key_valid, 0);
    @(negedge clk);
    rstn = 1'b1;
    m_valid = 0; m_code = 0; m_run = 0; m_prev = 0; have_prev = 0;
    hold(key(20), 3);
    check("reaccept_wait", key_valid, 0);
    run_frame(key(20));
    check("reaccept_20", key_code, 20);
    hold(key(0), 5);
    repeat (25) begin
      int kind = $urandom_range(0, 3);
      int a = $urandom_range(1, 20);
      int b = $urandom_range(1, 20);
      case (kind)
        0: hold(key(0), $urandom_range(1, 4));
        1: hold(key(a), $urandom_range(1, 6));
        2: hold(key(a) | key(b), $urandom_range(1, 3));
        default: for (int i = $urandom_range(2, 5); i > 0; i--) run_frame(key(i % 2 == 0 ? a : 0));
      endcase
    end
    hold(key(0), 5);
    check("no_press_and_release", n_both, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
